// File: rtl/pipe_scheduler.sv
// Pipe obstacle ring: loads the layout, scrolls and respawns pipes, tracks the pipe in
// front of the bird for the collision checker, and keeps the score.
module pipe_scheduler #(
   parameter int unsigned   NUM_PIPES    = 4,
   parameter int unsigned   PIPE_W       = 80,
   parameter int unsigned   PIPE_SPACING = 200,
   parameter int unsigned   SPAWN_X      = 200,
   parameter int unsigned   SPEED        = 2,
   parameter int unsigned   GAP_MIN      = 40,
   parameter logic [9:0]    LFSR_SEED    = 10'h2A5,
   localparam int unsigned  IDX_W        = $clog2(NUM_PIPES)
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             Start,
   input  logic             Ack,
   input  logic             Tick,
   input  logic             Lose,
   input  logic [9:0]       Bird_X,
   input  logic [IDX_W-1:0] Rd_Idx,
   output logic [9:0]       X_Edge,
   output logic [9:0]       Y_Edge,
   output logic [9:0]       Rd_X,
   output logic [9:0]       Rd_Y,
   output logic [7:0]       Score,
   output logic [IDX_W-1:0] Cur_Idx,
   output logic             Q_Idle,
   output logic             Q_Load,
   output logic             Q_Run,
   output logic             Q_Halt
);

   localparam logic [10:0] RING_11   = 11'(NUM_PIPES * PIPE_SPACING);
   localparam logic [10:0] SPEED_11  = 11'(SPEED);
   localparam logic [9:0]  SPEED_10  = 10'(SPEED);
   localparam logic [10:0] PIPE_W_11 = 11'(PIPE_W);
   localparam logic [9:0]  GAP_10    = 10'(GAP_MIN);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_t;

   state_t           state_q, state_d;
   logic [9:0]       x_q [NUM_PIPES];
   logic [9:0]       x_d [NUM_PIPES];
   logic [9:0]       y_q [NUM_PIPES];
   logic [9:0]       y_d [NUM_PIPES];
   logic [9:0]       lfsr_q, lfsr_d;
   logic [IDX_W-1:0] cur_q, cur_d;
   logic [IDX_W-1:0] k_q, k_d;
   logic [7:0]       score_q, score_d;
   logic             pass;

   function automatic logic [9:0] lfsr_step(input logic [9:0] v);
      return {v[8:0], v[9] ^ v[6]};
   endfunction

   function automatic logic [9:0] gap_of(input logic [9:0] v);
      return GAP_10 + {2'b00, v[7:0]};
   endfunction

   // Bird has cleared the current pipe once its right edge is strictly behind Bird_X
   assign pass = ({1'b0, x_q[cur_q]} + PIPE_W_11) < {1'b0, Bird_X};

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      lfsr_d  = lfsr_q;
      cur_d   = cur_q;
      k_d     = k_q;
      score_d = score_q;
      unique case (state_q)
         S_IDLE: begin
            if (Start) begin
               state_d = S_LOAD;
               score_d = '0;
               cur_d   = '0;
               k_d     = '0;
            end
         end
         S_LOAD: begin
            x_d[k_q] = 10'(SPAWN_X + 32'(k_q) * PIPE_SPACING);
            y_d[k_q] = gap_of(lfsr_q);
            lfsr_d   = lfsr_step(lfsr_q);
            k_d      = k_q + 1'b1;
            if (k_q == IDX_W'(NUM_PIPES - 1)) state_d = S_RUN;
         end
         S_RUN: begin
            if (Lose) begin
               state_d = S_HALT;
            end else begin
               if (pass) begin
                  cur_d = cur_q + 1'b1;
                  if (score_q != 8'hFF) score_d = score_q + 8'd1;
               end
               // Respawns draw gaps in ascending slot order, one LFSR step each
               if (Tick) begin
                  for (int unsigned i = 0; i < NUM_PIPES; i++) begin
                     if (x_q[i] < SPEED_10) begin
                        x_d[i] = 10'({1'b0, x_q[i]} + RING_11 - SPEED_11);
                        y_d[i] = gap_of(lfsr_d);
                        lfsr_d = lfsr_step(lfsr_d);
                     end else begin
                        x_d[i] = x_q[i] - SPEED_10;
                     end
                  end
               end
            end
         end
         S_HALT: begin
            if (Ack) state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         x_q     <= '{default: '0};
         y_q     <= '{default: '0};
         lfsr_q  <= LFSR_SEED;
         cur_q   <= '0;
         k_q     <= '0;
         score_q <= '0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         lfsr_q  <= lfsr_d;
         cur_q   <= cur_d;
         k_q     <= k_d;
         score_q <= score_d;
      end
   end

   assign X_Edge  = x_q[cur_q];
   assign Y_Edge  = y_q[cur_q];
   assign Rd_X    = x_q[Rd_Idx];
   assign Rd_Y    = y_q[Rd_Idx];
   assign Score   = score_q;
   assign Cur_Idx = cur_q;
   assign Q_Idle  = (state_q == S_IDLE);
   assign Q_Load  = (state_q == S_LOAD);
   assign Q_Run   = (state_q == S_RUN);
   assign Q_Halt  = (state_q == S_HALT);

endmodule
